// File: rtl/countdown_timer.sv
// countdown_timer
//   Preset count-down timer with start/stop/clear controls. The timer loads a
//   preset, decrements it once every TICK_DIV clocks while running, and on
//   reaching zero gives a one-cycle done pulse and holds a sticky expired flag.
//
// Parameters
//   WIDTH     width of the count and preset
//   TICK_DIV  clock cycles per decrement (>= 1)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   load        in   capture load_value into the count (returns to IDLE)
//   load_value  in   [WIDTH-1:0] preset value
//   start       in   begin or resume counting
//   stop        in   pause counting
//   clear       in   abort and zero the count
//   remaining   out  [WIDTH-1:0] current count, registered
//   running     out  high while counting (RUN)
//   expired     out  high while in DONE
//   done        out  one-cycle pulse on the first DONE cycle
module countdown_timer #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic [WIDTH-1:0] remaining,
  output logic             running,
  output logic             expired,
  output logic             done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] rem_n;
  logic [PW-1:0]    pre, pre_n;
  logic             done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      pre       <= '0;
      running   <= 1'b0;
      expired   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= rem_n;
      pre       <= pre_n;
      running   <= (state_n == RUN);
      expired   <= (state_n == DONE);
      done      <= done_n;
    end
  end

  // Priority: clear > load > stop > start. stop outranking start is what makes
  // a simultaneous start+stop a no-op in IDLE and PAUSE.
  always_comb begin
    state_n = state;
    rem_n   = remaining;
    pre_n   = pre;
    done_n  = 1'b0;

    if (clear) begin
      state_n = IDLE;
      rem_n   = '0;
      pre_n   = '0;
    end else if (load) begin
      state_n = IDLE;
      rem_n   = load_value;
      pre_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!stop && start && (remaining != '0)) begin
            state_n = RUN;
            pre_n   = '0;
          end
        end
        RUN: begin
          if (stop) begin
            // A tick due this cycle is deferred; prescaler keeps its phase.
            state_n = PAUSE;
          end else if (pre == PRE_LAST) begin
            pre_n = '0;
            if (remaining != '0) begin
              rem_n = remaining - WIDTH'(1);
            end
            if (remaining <= WIDTH'(1)) begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end else begin
            pre_n = pre + PW'(1);
          end
        end
        PAUSE: begin
          if (!stop && start) begin
            state_n = RUN;
          end
        end
        DONE: begin
          rem_n = '0;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (TICK_DIV=1 and TICK_DIV=4) driven
// by the same inputs, each compared every cycle to a model that derives the
// count as preset - floor(counting_cycles / TICK_DIV).
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        rst, load, start, stop, clear;
  logic [15:0] load_value;
  logic [15:0] rem0, rem1;
  logic        run0, run1, exp0, exp1, done0, done1;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(16), .TICK_DIV(1)) dut0 (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .clear(clear),
    .remaining(rem0), .running(run0), .expired(exp0), .done(done0)
  );

  countdown_timer #(.WIDTH(16), .TICK_DIV(4)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .clear(clear),
    .remaining(rem1), .running(run1), .expired(exp1), .done(done1)
  );

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
  mstate_t m_st  [2];
  int      m_base[2];
  int      m_cyc [2];
  int      m_td  [2];
  bit      m_done[2];

  function automatic int mrem(input int i);
    return m_base[i] - (m_cyc[i] / m_td[i]);
  endfunction

  task automatic model_update(input int i, input logic r, input logic l,
                              input logic [15:0] v, input logic s,
                              input logic p, input logic c);
    m_done[i] = 1'b0;
    if (r || c) begin
      m_st[i] = M_IDLE; m_base[i] = 0; m_cyc[i] = 0;
    end else if (l) begin
      m_st[i] = M_IDLE; m_base[i] = int'(v); m_cyc[i] = 0;
    end else begin
      case (m_st[i])
        M_IDLE:  if (!p && s && mrem(i) != 0) m_st[i] = M_RUN;
        M_RUN: begin
          if (p) m_st[i] = M_PAUSE;
          else begin
            m_cyc[i]++;
            if (mrem(i) == 0) begin
              m_st[i] = M_DONE; m_done[i] = 1'b1;
            end
          end
        end
        M_PAUSE: if (!p && s) m_st[i] = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [15:0] v,
                      input logic s, input logic p, input logic c);
    rst = r; load = l; load_value = v; start = s; stop = p; clear = c;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_update(i, r, l, v, s, p, c);
    #1;
    check("remaining0", 32'(rem0), 32'(mrem(0)));
    check("running0",   32'(run0), 32'(m_st[0] == M_RUN));
    check("expired0",   32'(exp0), 32'(m_st[0] == M_DONE));
    check("done0",      32'(done0), 32'(m_done[0]));
    check("remaining1", 32'(rem1), 32'(mrem(1)));
    check("running1",   32'(run1), 32'(m_st[1] == M_RUN));
    check("expired1",   32'(exp1), 32'(m_st[1] == M_DONE));
    check("done1",      32'(done1), 32'(m_done[1]));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 16'd0, 0, 0, 0);
  endtask
  task automatic do_load(input logic [15:0] v); step(0, 1, v, 0, 0, 0); endtask
  task automatic do_start();                    step(0, 0, 16'd0, 1, 0, 0); endtask
  task automatic do_stop();                     step(0, 0, 16'd0, 0, 1, 0); endtask

  initial begin
    m_td[0] = 1; m_td[1] = 4;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = M_IDLE; m_base[i] = 0; m_cyc[i] = 0; m_done[i] = 0;
    end
    rst = 1; load = 0; load_value = '0; start = 0; stop = 0; clear = 0;

    // Reset state
    step(1, 0, 16'd0, 0, 0, 0);
    step(1, 0, 16'd0, 0, 0, 0);

    // Start with zero count after reset is ignored
    do_start();
    idle(2);

    // Basic countdown, then start/stop while in DONE
    do_load(16'd10);
    do_start();
    idle(12);
    do_start();
    do_stop();
    step(0, 0, 16'd0, 1, 1, 0);
    idle(32);
    check("basic_expired0", 32'(exp0), 32'd1);

    // Load 0 never produces done
    do_load(16'd0);
    idle(2);
    do_start();
    idle(3);

    // Pause/resume: frozen at 15, start+stop in PAUSE stays paused
    do_load(16'd20);
    do_start();
    idle(5);
    do_stop();
    check("pause_frozen0", 32'(rem0), 32'd15);
    idle(4);
    step(0, 0, 16'd0, 1, 1, 0);
    check("pause_held0", 32'(rem0), 32'd15);
    do_stop();
    do_start();
    idle(90);

    // Prescaler pause mid-interval
    do_load(16'd3);
    do_start();
    idle(1);
    do_stop();
    idle(2);
    do_start();
    idle(14);

    // Priority: clear with load, load while running
    do_load(16'd30);
    do_start();
    idle(3);
    step(0, 1, 16'd9, 0, 0, 1);
    check("clear_over_load0", 32'(rem0), 32'd0);
    do_load(16'd30);
    do_start();
    idle(3);
    do_load(16'd7);
    check("load_in_run0", 32'(rem0), 32'd7);
    check("load_in_run_running0", 32'(run0), 32'd0);

    // Reset mid-operation, then a fresh countdown
    do_load(16'd40);
    do_start();
    idle(5);
    step(1, 0, 16'd0, 0, 0, 0);
    do_load(16'd5);
    do_start();
    idle(25);

    // Randomised control traffic
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 15) == 0),
           16'($urandom_range(0, 24)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
